pc_sequencer: RTL and testbench

Fetch-side controller for the program counter datapath. Each cycle it chooses the PC action (None, Inc, Branch or Jump) and supplies the matching offset or jump field. It arbitrates between a taken-branch redirect from execute and a jump from decode, holds a redirect while an instruction-memory fetch is in flight, and generates front-end flushes. It sits between the hazard unit, the instruction memory port and the PC register.

---
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: hazard, fetch and redirect inputs plus PC action outputs.
// master drives the inputs of the sequencer, slave is the sequencer itself.
interface pc_sequencer_if #(
    parameter int OFFSET_W = 16,
    parameter int JUMP_W   = 26
);
    logic                stall;
    logic                halt;
    logic                imem_ready;
    logic                br_valid;
    logic [OFFSET_W-1:0] br_offset;
    logic                jmp_valid;
    logic [JUMP_W-1:0]   jmp_target;
    logic [1:0]          act;
    logic [OFFSET_W-1:0] offset;
    logic [JUMP_W-1:0]   jump;
    logic                imem_req;
    logic                flush_if;
    logic                flush_id;
    logic                busy;

    modport master (
        output stall, halt, imem_ready,
        output br_valid, br_offset,
        output jmp_valid, jmp_target,
        input  act, offset, jump,
        input  imem_req, flush_if, flush_id, busy
    );

    modport slave (
        input  stall, halt, imem_ready,
        input  br_valid, br_offset,
        input  jmp_valid, jmp_target,
        output act, offset, jump,
        output imem_req, flush_if, flush_id, busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: picks the PC action each cycle, arbitrates branch/jump
// redirects, parks a redirect while a fetch is outstanding, drives flushes.
module pc_sequencer #(
    parameter int OFFSET_W    = 16,
    parameter int JUMP_W      = 26,
    parameter int BOOT_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_WAIT,
        S_HALTED
    } state_t;

    localparam logic [1:0] ACT_NONE = 2'd0;
    localparam logic [1:0] ACT_INC  = 2'd1;
    localparam logic [1:0] ACT_BR   = 2'd2;
    localparam logic [1:0] ACT_JMP  = 2'd3;
    localparam int         CW       = $clog2(BOOT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BOOT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
    logic                r_pend_br;
    logic                w_pend_br_nx;
    logic [OFFSET_W-1:0] r_pend_off;
    logic [OFFSET_W-1:0] w_pend_off_nx;
    logic [JUMP_W-1:0]   r_pend_jmp;
    logic [JUMP_W-1:0]   w_pend_jmp_nx;
    logic                r_halt;
    logic                w_halt_nx;

    logic                w_cand;
    logic                w_cand_br;
    logic                w_fresh;
    logic [OFFSET_W-1:0] w_cand_off;
    logic [JUMP_W-1:0]   w_cand_jmp;

    logic [1:0]          w_act;
    logic [OFFSET_W-1:0] w_offset;
    logic [JUMP_W-1:0]   w_jump;
    logic                w_req;
    logic                w_flush_if;
    logic                w_flush_id;
    logic                w_busy;

    // Redirect that owns this cycle; w_fresh marks one not yet flushed.
    always_comb begin
        w_cand     = 1'b0;
        w_cand_br  = 1'b0;
        w_fresh    = 1'b0;
        w_cand_off = '0;
        w_cand_jmp = '0;
        unique case (r_state)
            S_RUN: begin
                if (bus.br_valid) begin
                    w_cand     = 1'b1;
                    w_cand_br  = 1'b1;
                    w_fresh    = 1'b1;
                    w_cand_off = bus.br_offset;
                end else if (bus.jmp_valid) begin
                    w_cand     = 1'b1;
                    w_fresh    = 1'b1;
                    w_cand_jmp = bus.jmp_target;
                end
            end
            S_WAIT: begin
                w_cand = 1'b1;
                if (bus.br_valid && !r_pend_br) begin
                    w_cand_br  = 1'b1;
                    w_fresh    = 1'b1;
                    w_cand_off = bus.br_offset;
                end else begin
                    w_cand_br  = r_pend_br;
                    w_cand_off = r_pend_off;
                    w_cand_jmp = r_pend_jmp;
                end
            end
            S_BOOT, S_HALTED: begin
            end
        endcase
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_pend_br_nx  = r_pend_br;
        w_pend_off_nx = r_pend_off;
        w_pend_jmp_nx = r_pend_jmp;
        w_halt_nx     = r_halt;
        w_act         = ACT_NONE;
        w_offset      = '0;
        w_jump        = '0;
        w_req         = 1'b0;
        w_flush_if    = 1'b0;
        w_flush_id    = 1'b0;
        w_busy        = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_busy = 1'b1;
                if (bus.halt) begin
                    w_state_nx = S_HALTED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_RUN;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_RUN, S_WAIT: begin
                w_req      = 1'b1;
                w_busy     = (r_state == S_WAIT);
                w_flush_if = w_fresh;
                w_flush_id = w_fresh && w_cand_br;
                if (bus.imem_ready) begin
                    if (w_cand && w_cand_br) begin
                        w_act    = ACT_BR;
                        w_offset = w_cand_off;
                    end else if (w_cand) begin
                        w_act  = ACT_JMP;
                        w_jump = w_cand_jmp;
                    end else if (!bus.stall) begin
                        w_act = ACT_INC;
                    end
                    w_state_nx    = (bus.halt || r_halt) ? S_HALTED : S_RUN;
                    w_halt_nx     = 1'b0;
                    w_pend_br_nx  = 1'b0;
                    w_pend_off_nx = '0;
                    w_pend_jmp_nx = '0;
                end else if (w_cand) begin
                    w_state_nx    = S_WAIT;
                    w_pend_br_nx  = w_cand_br;
                    w_pend_off_nx = w_cand_off;
                    w_pend_jmp_nx = w_cand_jmp;
                    w_halt_nx     = r_halt || bus.halt;
                end else if (bus.halt) begin
                    w_state_nx = S_HALTED;
                end
            end
            S_HALTED: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_cnt      <= '0;
            r_pend_br  <= 1'b0;
            r_pend_off <= '0;
            r_pend_jmp <= '0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_pend_br  <= w_pend_br_nx;
            r_pend_off <= w_pend_off_nx;
            r_pend_jmp <= w_pend_jmp_nx;
            r_halt     <= w_halt_nx;
        end
    end

    assign bus.act      = w_act;
    assign bus.offset   = w_offset;
    assign bus.jump     = w_jump;
    assign bus.imem_req = w_req;
    assign bus.flush_if = w_flush_if;
    assign bus.flush_id = w_flush_id;
    assign bus.busy     = w_busy;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios then random traffic, each cycle
// checked against a queue-based model of the redirect/halt rules.
module tb_pc_sequencer;
    localparam int OW = 16;
    localparam int JW = 26;
    localparam int BC = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pc_sequencer_if #(.OFFSET_W(OW), .JUMP_W(JW)) bus ();

    pc_sequencer #(
        .OFFSET_W(OW),
        .JUMP_W(JW),
        .BOOT_CYCLES(BC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit            is_br;
        logic [OW-1:0] off;
        logic [JW-1:0] tgt;
    } redir_t;

    int errors = 0;
    int checks = 0;

    redir_t pend[$];
    int     boot_left;
    bit     halted;
    bit     halt_lat;
    bit     in_reset;

    logic [1:0]    e_act;
    logic [OW-1:0] e_off;
    logic [JW-1:0] e_jmp;
    logic          e_req, e_fif, e_fid, e_busy;
    bit            c_have, c_fresh;
    redir_t        c_r;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, got, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_act = 0; e_off = '0; e_jmp = '0;
        e_req = 0; e_fif = 0; e_fid = 0; e_busy = 0;
        c_have = 0; c_fresh = 0;
        c_r.is_br = 0; c_r.off = '0; c_r.tgt = '0;
        if (in_reset || boot_left > 0) begin
            e_busy = 1;
            return;
        end
        if (halted) return;
        e_req  = 1;
        e_busy = (pend.size() != 0);
        if (pend.size() != 0) begin
            c_have = 1;
            c_r = pend[0];
            if (!pend[0].is_br && bus.br_valid) begin
                c_r.is_br = 1; c_r.off = bus.br_offset; c_r.tgt = '0;
                c_fresh = 1;
            end
        end else if (bus.br_valid) begin
            c_have = 1; c_fresh = 1;
            c_r.is_br = 1; c_r.off = bus.br_offset;
        end else if (bus.jmp_valid) begin
            c_have = 1; c_fresh = 1;
            c_r.is_br = 0; c_r.tgt = bus.jmp_target;
        end
        if (c_fresh) begin
            e_fif = 1;
            e_fid = c_r.is_br;
        end
        if (bus.imem_ready) begin
            if (c_have && c_r.is_br) begin
                e_act = 2; e_off = c_r.off;
            end else if (c_have) begin
                e_act = 3; e_jmp = c_r.tgt;
            end else if (!bus.stall) begin
                e_act = 1;
            end
        end
    endtask

    task automatic model_edge();
        if (in_reset) return;
        if (boot_left > 0) begin
            if (bus.halt) begin
                halted = 1; boot_left = 0;
            end else begin
                boot_left--;
            end
            return;
        end
        if (halted) return;
        if (bus.imem_ready) begin
            pend.delete();
            if (bus.halt || halt_lat) halted = 1;
            halt_lat = 0;
        end else if (c_have) begin
            pend.delete();
            pend.push_back(c_r);
            if (bus.halt) halt_lat = 1;
        end else if (bus.halt) begin
            halted = 1;
        end
    endtask

    task automatic cmp_all();
        model_eval();
        chk("act",      32'(bus.act),      32'(e_act));
        chk("offset",   32'(bus.offset),   32'(e_off));
        chk("jump",     32'(bus.jump),     32'(e_jmp));
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("flush_if", 32'(bus.flush_if), 32'(e_fif));
        chk("flush_id", 32'(bus.flush_id), 32'(e_fid));
        chk("busy",     32'(bus.busy),     32'(e_busy));
    endtask

    // Entered and left at a negedge.
    task automatic step(bit st, bit hl, bit rdy, bit bv,
                        logic [OW-1:0] bo, bit jv, logic [JW-1:0] jt);
        bus.stall      = st;
        bus.halt       = hl;
        bus.imem_ready = rdy;
        bus.br_valid   = bv;
        bus.br_offset  = bo;
        bus.jmp_valid  = jv;
        bus.jmp_target = jt;
        #1;
        cmp_all();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_reset = 1; halted = 0; halt_lat = 0;
        boot_left = BC;
        pend.delete();
        #1;
        cmp_all();
        @(negedge clock);
        reset = 1'b1;
        in_reset = 0;
    endtask

    initial begin
        bus.stall = 0; bus.halt = 0; bus.imem_ready = 0;
        bus.br_valid = 0; bus.br_offset = '0;
        bus.jmp_valid = 0; bus.jmp_target = '0;
        @(negedge clock);
        do_reset();
        repeat (BC) step(0, 0, 1, 0, '0, 0, '0);
        repeat (3) step(0, 0, 1, 0, '0, 0, '0);
        // branch and jump together: branch wins
        step(0, 0, 1, 1, 16'hFFFD, 1, 26'h3ABCDE);
        step(0, 0, 1, 0, '0, 0, '0);
        // jump parked across three not-ready cycles
        step(0, 0, 0, 0, '0, 1, 26'h123456);
        step(0, 0, 0, 0, '0, 0, '0);
        step(0, 0, 0, 0, '0, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        // pending jump displaced by a branch; later branch ignored
        step(0, 0, 0, 0, '0, 1, 26'h0ABCDE);
        step(0, 0, 0, 1, 16'd8, 0, '0);
        step(0, 0, 0, 1, 16'h0777, 0, '0);
        step(0, 0, 0, 0, '0, 1, 26'h1);
        step(0, 0, 1, 0, '0, 0, '0);
        // stall versus redirect
        step(1, 0, 1, 1, 16'h0010, 0, '0);
        repeat (3) step(1, 0, 1, 0, '0, 0, '0);
        step(1, 0, 0, 0, '0, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        // halt while a jump is parked
        step(0, 0, 0, 0, '0, 1, 26'h2222);
        step(0, 1, 0, 0, '0, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        step(0, 0, 1, 1, 16'h5, 1, 26'h7);
        // reset in the middle of a parked branch
        do_reset();
        repeat (BC) step(0, 0, 1, 0, '0, 0, '0);
        step(0, 0, 0, 1, 16'h4, 0, '0);
        step(0, 0, 0, 0, '0, 0, '0);
        bus.imem_ready = 1; bus.br_valid = 1;
        do_reset();
        repeat (BC) step(0, 0, 1, 0, '0, 0, '0);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ((halted && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 39) == 0,
                     $urandom_range(0, 9) < 6,
                     $urandom_range(0, 4) == 0,
                     OW'($urandom),
                     $urandom_range(0, 3) == 0,
                     JW'($urandom));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
